// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c_master request path: FIFO word layout and
// the frontend parser states.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int REQ_W  = ADDR_W + DATA_W;

  // Request FIFO word: addr in [14:8], data in [7:0]
  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = DATA_LSB + DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    DROP
  } state_t;

  function automatic logic [REQ_W-1:0] pack_req(input logic [ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0] data);
    logic [REQ_W-1:0] req;
    req = '0;
    req[ADDR_LSB +: ADDR_W] = addr;
    req[DATA_LSB +: DATA_W] = data;
    return req;
  endfunction

endpackage

// File: rtl/axis_i2c_frontend.sv
// Parses byte-wide AXI-Stream write packets (address beat + data beats) into
// i2c_master request FIFO words, with sticky format-error flags.
module axis_i2c_frontend
  import i2c_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [REQ_W-1:0]  fifo_data,
  output logic              busy,
  output logic              err_rw,
  output logic              err_empty,
  output logic              err_len,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  pkt_cnt
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_LEN - 1);

  localparam int ERR_RW    = 0;
  localparam int ERR_EMPTY = 1;
  localparam int ERR_LEN   = 2;
  localparam int N_ERR     = 3;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               cnt_inc;
  logic               tready_int;
  logic [N_ERR-1:0]   err_reg, err_next, err_set;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    len_next   = len_reg;
    cnt_inc    = 1'b0;
    err_set    = '0;
    tready_int = 1'b0;
    case (state_reg)
      IDLE: begin
        tready_int = 1'b1;
        if (s_axis_tvalid) begin
          if (s_axis_tdata[7]) begin
            err_set[ERR_RW] = 1'b1;
            if (!s_axis_tlast) state_next = DROP;
          end else if (s_axis_tlast) begin
            err_set[ERR_EMPTY] = 1'b1;
          end else begin
            addr_next  = s_axis_tdata[ADDR_W-1:0];
            len_next   = '0;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        // Backpressure from the FIFO stalls the stream; all state holds.
        tready_int = !fifo_full;
        if (s_axis_tvalid && !fifo_full) begin
          len_next = len_reg + LEN_W'(1);
          if (s_axis_tlast) begin
            cnt_inc    = 1'b1;
            state_next = IDLE;
          end else if (len_reg == LAST_IDX) begin
            cnt_inc          = 1'b1;
            err_set[ERR_LEN] = 1'b1;
            state_next       = DROP;
          end
        end
      end
      DROP: begin
        tready_int = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cnt_next = cnt_reg + CNT_W'(cnt_inc);

  // A new error event takes priority over a coincident clear.
  generate
    for (genvar gi = 0; gi < N_ERR; gi++) begin : g_err
      assign err_next[gi] = err_set[gi] | (err_reg[gi] & ~err_clr);
    end
  endgenerate

  assign s_axis_tready = arst_n & tready_int;
  assign fifo_wr_en    = arst_n & (state_reg == DATA) & s_axis_tvalid & !fifo_full;
  assign fifo_data     = pack_req(addr_reg, s_axis_tdata);
  assign busy          = (state_reg != IDLE);
  assign err_rw        = err_reg[ERR_RW];
  assign err_empty     = err_reg[ERR_EMPTY];
  assign err_len       = err_reg[ERR_LEN];
  assign pkt_cnt       = cnt_reg;

endmodule

// File: tb/tb_axis_i2c_frontend.sv
// Directed testbench for axis_i2c_frontend: writes are logged on the falling
// edge and compared against hand-computed FIFO words.
module tb_axis_i2c_frontend;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [14:0] fifo_data;
  logic        busy;
  logic        err_rw;
  logic        err_empty;
  logic        err_len;
  logic        err_clr;
  logic [15:0] pkt_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int full_viol = 0;
  logic [14:0] log_q[$];
  int          log_cyc[$];

  always #5 clk = ~clk;

  axis_i2c_frontend #(.MAX_LEN(16), .CNT_W(16)) dut (
    .clk(clk), .arst_n(arst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
    .busy(busy), .err_rw(err_rw), .err_empty(err_empty), .err_len(err_len),
    .err_clr(err_clr), .pkt_cnt(pkt_cnt)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_wr_en) begin
      log_q.push_back(fifo_data);
      log_cyc.push_back(cyc);
      $display("write: cycle %0d data 0x%04h", cyc, fifo_data);
    end
    if (fifo_wr_en && fifo_full) full_viol++;
  end

  task automatic send_beat(input logic [7:0] d, input logic last, output int waits);
    int w;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!s_axis_tready && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (!s_axis_tready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: tready=%0b required 1 for byte 0x%02h", s_axis_tready, d);
    end
    @(posedge clk);
    #1;
    waits = w;
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = 8'h00;
    fifo_full = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_axis_tready, fifo_wr_en, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: {tready,wr_en,busy}=%b required 000", {s_axis_tready, fifo_wr_en, busy});
    end
    checks++;
    if ({err_rw, err_empty, err_len} !== 3'b000 || pkt_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_stat: errs=%b pkt_cnt=%0d required 000 0", {err_rw, err_empty, err_len}, pkt_cnt);
    end
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_tready: got %0b required 1", s_axis_tready);
    end
    @(posedge clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_single();
    int w;
    clear_log();
    send_beat(8'h50, 1'b0, w);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_mid: got %0b required 1", busy);
    end
    send_beat(8'hA5, 1'b1, w);
    idle();
    checks++;
    if (log_q.size() != 1 || log_q[0] !== 15'h50A5) begin
      errors++;
      $display("FAIL single_write: count %0d first 0x%04h required 1 0x50A5", log_q.size(),
               (log_q.size() > 0) ? log_q[0] : 15'h0);
    end
    checks++;
    if (pkt_cnt !== 16'd1 || busy !== 1'b0 || {err_rw, err_empty, err_len} !== 3'b000) begin
      errors++;
      $display("FAIL single_status: pkt_cnt=%0d busy=%0b errs=%b required 1 0 000",
               pkt_cnt, busy, {err_rw, err_empty, err_len});
    end
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    int w;
    logic [14:0] exp_w[3] = '{15'h3C01, 15'h3C02, 15'h3C03};
    clear_log();
    send_beat(8'h3C, 1'b0, w);
    send_beat(8'h01, 1'b0, w);
    send_beat(8'h02, 1'b0, w);
    send_beat(8'h03, 1'b1, w);
    idle();
    checks++;
    if (log_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d required 3", log_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (log_q[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL b2b_word%0d: got 0x%04h required 0x%04h", i, log_q[i], exp_w[i]);
        end
      end
      checks++;
      if (log_cyc[1] != log_cyc[0] + 1 || log_cyc[2] != log_cyc[1] + 1) begin
        errors++;
        $display("FAIL b2b_consecutive: cycles %0d %0d %0d required consecutive",
                 log_cyc[0], log_cyc[1], log_cyc[2]);
      end
    end
    checks++;
    if (pkt_cnt !== 16'd2) begin
      errors++;
      $display("FAIL b2b_pkt_cnt: got %0d required 2", pkt_cnt);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_stall();
    int w;
    int bad;
    logic [14:0] exp_w[3] = '{15'h3C01, 15'h3C02, 15'h3C03};
    clear_log();
    full_viol = 0;
    send_beat(8'h3C, 1'b0, w);
    send_beat(8'h01, 1'b0, w);
    s_axis_tdata = 8'h02; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    fifo_full = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (s_axis_tready !== 1'b0 || fifo_wr_en !== 1'b0 || busy !== 1'b1) bad++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d stalled cycles had tready/wr_en high or busy low, required 0", bad);
    end
    fifo_full = 1'b0;
    send_beat(8'h02, 1'b0, w);
    send_beat(8'h03, 1'b1, w);
    idle();
    checks++;
    if (log_q.size() != 3) begin
      errors++;
      $display("FAIL stall_count: got %0d required 3", log_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (log_q[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL stall_word%0d: got 0x%04h required 0x%04h", i, log_q[i], exp_w[i]);
        end
      end
    end
    checks++;
    if (full_viol != 0 || pkt_cnt !== 16'd3) begin
      errors++;
      $display("FAIL stall_status: full_viol=%0d pkt_cnt=%0d required 0 3", full_viol, pkt_cnt);
    end
    $display("test_stall done");
  endtask

  task automatic test_rw_err();
    int w;
    clear_log();
    send_beat(8'h90, 1'b0, w);
    send_beat(8'h11, 1'b0, w);
    send_beat(8'h22, 1'b1, w);
    idle();
    checks++;
    if (err_rw !== 1'b1 || log_q.size() != 0 || pkt_cnt !== 16'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rw_err: err_rw=%0b writes=%0d pkt_cnt=%0d busy=%0b required 1 0 3 0",
               err_rw, log_q.size(), pkt_cnt, busy);
    end
    send_beat(8'h50, 1'b0, w);
    send_beat(8'hA5, 1'b1, w);
    idle();
    checks++;
    if (log_q.size() != 1 || log_q[0] !== 15'h50A5 || pkt_cnt !== 16'd4) begin
      errors++;
      $display("FAIL rw_recover: writes=%0d pkt_cnt=%0d required 1 (0x50A5) 4", log_q.size(), pkt_cnt);
    end
    $display("test_rw_err done");
  endtask

  task automatic test_empty();
    int w;
    clear_log();
    send_beat(8'h20, 1'b1, w);
    idle();
    checks++;
    if (err_empty !== 1'b1 || log_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_err: err_empty=%0b writes=%0d busy=%0b required 1 0 0",
               err_empty, log_q.size(), busy);
    end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    checks++;
    if ({err_rw, err_empty, err_len} !== 3'b000) begin
      errors++;
      $display("FAIL err_clr: errs=%b required 000", {err_rw, err_empty, err_len});
    end
    // clear coincident with a new empty-packet event
    err_clr = 1'b1;
    send_beat(8'h20, 1'b1, w);
    err_clr = 1'b0;
    idle();
    checks++;
    if ({err_rw, err_empty, err_len} !== 3'b010) begin
      errors++;
      $display("FAIL set_wins: errs=%b required 010", {err_rw, err_empty, err_len});
    end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    $display("test_empty done");
  endtask

  task automatic test_len();
    int w;
    int wsum;
    logic [7:0] k;
    clear_log();
    send_beat(8'h33, 1'b0, w);
    for (int i = 1; i <= 16; i++) begin
      k = 8'(i);
      send_beat(k, 1'b0, w);
    end
    checks++;
    if (busy !== 1'b1 || err_len !== 1'b1) begin
      errors++;
      $display("FAIL len_drop_state: busy=%0b err_len=%0b required 1 1", busy, err_len);
    end
    wsum = 0;
    send_beat(8'd17, 1'b0, w); wsum += w;
    send_beat(8'd18, 1'b1, w); wsum += w;
    idle();
    checks++;
    if (wsum != 0) begin
      errors++;
      $display("FAIL len_drop_ready: stalled %0d cycles required 0", wsum);
    end
    checks++;
    if (log_q.size() != 16) begin
      errors++;
      $display("FAIL len_count: got %0d required 16", log_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        k = 8'(i + 1);
        checks++;
        if (log_q[i] !== {7'h33, k}) begin
          errors++;
          $display("FAIL len_word%0d: got 0x%04h required 0x%04h", i, log_q[i], {7'h33, k});
        end
      end
    end
    checks++;
    if (pkt_cnt !== 16'd5 || busy !== 1'b0 || err_len !== 1'b1) begin
      errors++;
      $display("FAIL len_status: pkt_cnt=%0d busy=%0b err_len=%0b required 5 0 1", pkt_cnt, busy, err_len);
    end
    $display("test_len done");
  endtask

  task automatic test_reset_mid();
    int w;
    clear_log();
    send_beat(8'h44, 1'b0, w);
    send_beat(8'h01, 1'b0, w);
    s_axis_tvalid = 1'b0;
    arst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || pkt_cnt !== 16'd0 || s_axis_tready !== 1'b0 ||
        {err_rw, err_empty, err_len} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid: busy=%0b pkt_cnt=%0d tready=%0b errs=%b required 0 0 0 000",
               busy, pkt_cnt, s_axis_tready, {err_rw, err_empty, err_len});
    end
    arst_n = 1'b1;
    clear_log();
    send_beat(8'h03, 1'b0, w);
    send_beat(8'h04, 1'b1, w);
    idle();
    checks++;
    if (log_q.size() != 1 || log_q[0] !== 15'h0304 || pkt_cnt !== 16'd1) begin
      errors++;
      $display("FAIL reset_mid_reparse: writes=%0d pkt_cnt=%0d required 1 (0x0304) 1",
               log_q.size(), pkt_cnt);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_rw_err();
    test_empty();
    test_len();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
